// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer: mode encodings and
// an index-width helper that never returns zero, even for degenerate channel counts.
package mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found scanning
// upward from ptr with wrap-around at N-1 -> 0. Produces one-hot grant plus index.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N     = 4,
  localparam int SEL_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [SEL_W:0] cand;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    // Candidate k is ptr+k folded back into 0..N-1; the extra bit holds the carry.
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (SEL_W+1)'(k);
      if (cand >= (SEL_W+1)'(N)) cand = cand - (SEL_W+1)'(N);
      if (!gnt_any && req[cand[SEL_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[SEL_W-1:0];
      end
    end
    grant[gnt_idx] = gnt_any;
  end

endmodule

// File: rtl/rr_stream_mux.sv
// Registered N:1 valid/ready stream multiplexer. Round-robin or fixed-channel
// arbitration feeds a single output register stage with full throughput.
module rr_stream_mux
  import mux_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int NUM_INPUTS = 4,
  localparam int SEL_W      = clog2_min1(NUM_INPUTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_INPUTS*WIDTH-1:0] In,
  input  logic [NUM_INPUTS-1:0]       in_valid,
  output logic [NUM_INPUTS-1:0]       in_ready,
  input  logic                        mode,
  input  logic [SEL_W-1:0]            select,
  output logic [WIDTH-1:0]            Out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SEL_W-1:0]            out_chan
);

  logic [WIDTH-1:0]      chan_data [NUM_INPUTS];
  logic [SEL_W-1:0]      rr_ptr;
  logic [NUM_INPUTS-1:0] rr_grant;
  logic [SEL_W-1:0]      rr_idx;
  logic                  rr_any;
  logic [NUM_INPUTS-1:0] fix_grant;
  logic                  fix_any;
  logic [NUM_INPUTS-1:0] grant;
  logic [SEL_W-1:0]      gnt_idx;
  logic                  gnt_any;
  logic                  load;
  logic                  accept;
  logic [SEL_W-1:0]      next_ptr;
  logic [WIDTH-1:0]      data_p1;
  logic [SEL_W-1:0]      chan_p1;
  logic                  vld_p1;

  // Channel 0 occupies the most significant slice of the packed bus.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_unpack
    assign chan_data[i] = In[(NUM_INPUTS-i)*WIDTH-1 -: WIDTH];
  end

  rr_arbiter #(.N(NUM_INPUTS)) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .grant   (rr_grant),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  always_comb begin
    fix_grant = '0;
    fix_any   = 1'b0;
    // An out-of-range select (non power-of-two channel counts) grants nothing.
    if ({1'b0, select} < (SEL_W+1)'(NUM_INPUTS)) begin
      fix_any           = in_valid[select];
      fix_grant[select] = in_valid[select];
    end
  end

  always_comb begin
    if (mode == MODE_FIXED) begin
      grant   = fix_grant;
      gnt_idx = select;
      gnt_any = fix_any;
    end else begin
      grant   = rr_grant;
      gnt_idx = rr_idx;
      gnt_any = rr_any;
    end
  end

  assign load     = !vld_p1 || out_ready;
  assign accept   = rst_n && load && gnt_any;
  assign in_ready = (rst_n && load) ? grant : '0;
  assign next_ptr = (gnt_idx == SEL_W'(NUM_INPUTS-1)) ? '0 : gnt_idx + 1'b1;

  // Stage p1: output register; a held beat is only replaced when downstream takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      chan_p1 <= '0;
      rr_ptr  <= '0;
    end else if (load) begin
      vld_p1 <= accept;
      if (accept) begin
        data_p1 <= chan_data[gnt_idx];
        chan_p1 <= gnt_idx;
        if (mode == MODE_RR) rr_ptr <= next_ptr;
      end
    end
  end

  assign Out       = data_p1;
  assign out_valid = vld_p1;
  assign out_chan  = chan_p1;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: a 4-channel instance tracked by a behavioural model,
// plus a 3-channel instance for the out-of-range fixed select case.
module tb_rr_stream_mux;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [W-1:0]   d [4];
  logic [4*W-1:0] bus4;
  logic [3:0]     iv4, ir4;
  logic           mode4, ordy4, ov4;
  logic [1:0]     sel4, oc4;
  logic [W-1:0]   out4;
  assign bus4 = {d[0], d[1], d[2], d[3]};

  logic [W-1:0]   d3 [3];
  logic [3*W-1:0] bus3;
  logic [2:0]     iv3, ir3;
  logic           mode3, ordy3, ov3;
  logic [1:0]     sel3, oc3;
  logic [W-1:0]   out3;
  assign bus3 = {d3[0], d3[1], d3[2]};

  rr_stream_mux #(.WIDTH(W), .NUM_INPUTS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .In(bus4), .in_valid(iv4), .in_ready(ir4),
    .mode(mode4), .select(sel4), .Out(out4), .out_valid(ov4),
    .out_ready(ordy4), .out_chan(oc4)
  );

  rr_stream_mux #(.WIDTH(W), .NUM_INPUTS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .In(bus3), .in_valid(iv3), .in_ready(ir3),
    .mode(mode3), .select(sel3), .Out(out3), .out_valid(ov3),
    .out_ready(ordy3), .out_chan(oc3)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state for dut4
  bit         m_vld = 1'b0;
  logic [W-1:0] m_data = '0;
  int         m_chan = 0;
  int         m_ptr = 0;

  function automatic int model_grant();
    if (mode4) return iv4[sel4] ? int'(sel4) : -1;
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (m_ptr + k) % 4;
      if (iv4[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ready();
    int g;
    logic [3:0] r;
    g = model_grant();
    r = 4'b0;
    if (rst_n && (!m_vld || ordy4) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic advance();
    int g;
    @(posedge clk);
    g = model_grant();
    if (!rst_n) begin
      m_vld = 1'b0; m_data = '0; m_chan = 0; m_ptr = 0;
    end else if (!m_vld || ordy4) begin
      if (g >= 0) begin
        m_vld = 1'b1; m_data = d[g]; m_chan = g;
        if (!mode4) m_ptr = (g + 1) % 4;
      end else begin
        m_vld = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; iv4 = 4'hF; iv3 = 3'h7; ordy4 = 1'b1; ordy3 = 1'b1;
    mode4 = 1'b0; mode3 = 1'b0; sel4 = 2'd0; sel3 = 2'd0;
    for (int i = 0; i < 4; i++) d[i] = $urandom;
    for (int i = 0; i < 3; i++) d3[i] = $urandom;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (ir4 !== 4'b0 || ir3 !== 3'b0) begin
        errors++; $display("FAIL reset_ready cyc %0d: got %b/%b want 0000/000", c, ir4, ir3);
      end
      advance();
      checks++;
      if (ov4 !== 1'b0 || out4 !== '0 || oc4 !== 2'd0 || ov3 !== 1'b0) begin
        errors++; $display("FAIL reset_out cyc %0d: got v%b d%h c%0d v3%b want v0 d0 c0 v3 0", c, ov4, out4, oc4, ov3);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (ir4 !== 4'b0001) begin
      errors++; $display("FAIL reset_first_grant: got %b want 0001", ir4);
    end
  endtask

  task automatic test_rr_fair();
    for (int i = 0; i < 4; i++) d[i] = 32'hA0 + i;
    iv4 = 4'hF; mode4 = 1'b0; ordy4 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (ir4 !== model_ready() || ir4 !== (4'b1 << (k % 4))) begin
        errors++; $display("FAIL rr_ready beat %0d: got %b want %b", k, ir4, 4'b1 << (k % 4));
      end
      advance();
      checks++;
      if (ov4 !== 1'b1 || oc4 !== 2'(k % 4) || out4 !== 32'hA0 + 32'(k % 4)) begin
        errors++; $display("FAIL rr_out beat %0d: got v%b c%0d d%h want v1 c%0d d%h", k, ov4, oc4, out4, k % 4, 32'hA0 + k % 4);
      end
    end
  endtask

  task automatic test_sparse_rr();
    int exp_seq [4] = '{3, 1, 3, 1};
    for (int i = 0; i < 4; i++) d[i] = $urandom;
    iv4 = 4'b0010;
    advance();
    checks++;
    if (ov4 !== 1'b1 || oc4 !== 2'd1 || out4 !== d[1]) begin
      errors++; $display("FAIL sparse_setup: got v%b c%0d d%h want v1 c1 d%h", ov4, oc4, out4, d[1]);
    end
    iv4 = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      d[exp_seq[k]] = $urandom;
      advance();
      checks++;
      if (ov4 !== 1'b1 || oc4 !== 2'(exp_seq[k]) || out4 !== d[exp_seq[k]]) begin
        errors++; $display("FAIL sparse_out beat %0d: got v%b c%0d d%h want v1 c%0d d%h", k, ov4, oc4, out4, exp_seq[k], d[exp_seq[k]]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held_d;
    logic [1:0]   held_c;
    iv4 = 4'hF; ordy4 = 1'b1;
    for (int i = 0; i < 4; i++) d[i] = $urandom;
    advance();
    held_d = out4; held_c = oc4;
    checks++;
    if (ov4 !== m_vld || oc4 !== 2'(m_chan) || out4 !== m_data) begin
      errors++; $display("FAIL bp_first: got v%b c%0d d%h want v%b c%0d d%h", ov4, oc4, out4, m_vld, m_chan, m_data);
    end
    ordy4 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 4; i++) d[i] = $urandom;
      #1;
      checks++;
      if (ir4 !== 4'b0) begin
        errors++; $display("FAIL bp_ready cyc %0d: got %b want 0000", c, ir4);
      end
      advance();
      checks++;
      if (ov4 !== 1'b1 || oc4 !== held_c || out4 !== held_d) begin
        errors++; $display("FAIL bp_hold cyc %0d: got v%b c%0d d%h want v1 c%0d d%h", c, ov4, oc4, out4, held_c, held_d);
      end
    end
    ordy4 = 1'b1;
    #1;
    checks++;
    if (ir4 !== model_ready() || ir4 !== (4'b1 << ((held_c + 1) % 4))) begin
      errors++; $display("FAIL bp_release_ready: got %b want %b", ir4, 4'b1 << ((held_c + 1) % 4));
    end
    advance();
    checks++;
    if (ov4 !== 1'b1 || oc4 !== 2'((held_c + 1) % 4) || out4 !== m_data) begin
      errors++; $display("FAIL bp_release_out: got v%b c%0d d%h want v1 c%0d d%h", ov4, oc4, out4, (held_c + 1) % 4, m_data);
    end
  endtask

  task automatic test_fixed();
    mode4 = 1'b1; sel4 = 2'd2; iv4 = 4'hF; ordy4 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 4; i++) d[i] = $urandom;
      #1;
      checks++;
      if (ir4 !== 4'b0100) begin
        errors++; $display("FAIL fixed_ready cyc %0d: got %b want 0100", c, ir4);
      end
      advance();
      checks++;
      if (ov4 !== 1'b1 || oc4 !== 2'd2 || out4 !== d[2]) begin
        errors++; $display("FAIL fixed_out cyc %0d: got v%b c%0d d%h want v1 c2 d%h", c, ov4, oc4, out4, d[2]);
      end
    end
    for (int c = 0; c < 20; c++) begin
      sel4 = 2'($urandom); iv4 = 4'($urandom); ordy4 = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) d[i] = $urandom;
      #1;
      checks++;
      if (ir4 !== model_ready()) begin
        errors++; $display("FAIL fixed_rand_ready cyc %0d: got %b want %b", c, ir4, model_ready());
      end
      advance();
      checks++;
      if (ov4 !== m_vld || oc4 !== 2'(m_chan) || out4 !== m_data) begin
        errors++; $display("FAIL fixed_rand_out cyc %0d: got v%b c%0d d%h want v%b c%0d d%h", c, ov4, oc4, out4, m_vld, m_chan, m_data);
      end
    end
    mode3 = 1'b1; sel3 = 2'd0; iv3 = 3'h7; ordy3 = 1'b1;
    for (int i = 0; i < 3; i++) d3[i] = $urandom;
    advance();
    checks++;
    if (ov3 !== 1'b1 || oc3 !== 2'd0 || out3 !== d3[0]) begin
      errors++; $display("FAIL fixed3_first: got v%b c%0d d%h want v1 c0 d%h", ov3, oc3, out3, d3[0]);
    end
    sel3 = 2'd3;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (ir3 !== 3'b0) begin
        errors++; $display("FAIL fixed3_ready cyc %0d: got %b want 000", c, ir3);
      end
      advance();
      checks++;
      if (ov3 !== 1'b0) begin
        errors++; $display("FAIL fixed3_drain cyc %0d: got v%b want v0", c, ov3);
      end
    end
    mode4 = 1'b0;
  endtask

  task automatic test_reset_mid();
    iv4 = 4'hF; ordy4 = 1'b1; mode4 = 1'b0;
    advance();
    advance();
    ordy4 = 1'b0;
    advance();
    rst_n = 1'b0;
    #1;
    checks++;
    if (ir4 !== 4'b0 || ov4 !== 1'b1) begin
      errors++; $display("FAIL mid_reset_pre: got ready %b v%b want 0000 v1", ir4, ov4);
    end
    advance();
    checks++;
    if (ov4 !== 1'b0 || out4 !== '0 || oc4 !== 2'd0) begin
      errors++; $display("FAIL mid_reset_out: got v%b c%0d d%h want v0 c0 d0", ov4, oc4, out4);
    end
    rst_n = 1'b1; ordy4 = 1'b1;
    #1;
    checks++;
    if (ir4 !== 4'b0001) begin
      errors++; $display("FAIL mid_reset_ptr: got %b want 0001", ir4);
    end
    advance();
    checks++;
    if (ov4 !== 1'b1 || oc4 !== 2'd0 || out4 !== d[0]) begin
      errors++; $display("FAIL mid_reset_resume: got v%b c%0d d%h want v1 c0 d%h", ov4, oc4, out4, d[0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      iv4 = 4'($urandom);
      ordy4 = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode4 = ~mode4;
      sel4 = 2'($urandom);
      rst_n = ($urandom_range(0, 31) != 0);
      for (int i = 0; i < 4; i++) d[i] = $urandom;
      #1;
      checks++;
      if (ir4 !== model_ready()) begin
        errors++; $display("FAIL rand_ready cyc %0d: got %b want %b", c, ir4, model_ready());
      end
      advance();
      checks++;
      if (ov4 !== m_vld || oc4 !== 2'(m_chan) || out4 !== m_data) begin
        errors++; $display("FAIL rand_out cyc %0d: got v%b c%0d d%h want v%b c%0d d%h", c, ov4, oc4, out4, m_vld, m_chan, m_data);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rr_fair();
    test_sparse_rr();
    test_backpressure();
    test_fixed();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
